// File: rtl/io_pattern_gen.sv
// Board-IO pattern source: drives NUM_PORTS x PORT_W header pins with a selectable pattern stepped every STEP_TICKS clocks.
// Define IO_PATTERN_LOOPBACK_EN to add the io_in read-back checker (err_cnt / err_flag).
module io_pattern_gen #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = 34,
    parameter int STEP_TICKS = 25_000_000,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [1:0]                    mode,
`ifdef IO_PATTERN_LOOPBACK_EN
    input  logic [NUM_PORTS*PORT_W-1:0]   io_in,
    output logic [CNT_W-1:0]              err_cnt,
    output logic                          err_flag,
`endif
    output logic [NUM_PORTS*PORT_W-1:0]   io_out,
    output logic                          step_pulse,
    output logic [CNT_W-1:0]              step_cnt
);

    localparam int TOTAL_W = NUM_PORTS * PORT_W;
    localparam int TIMER_W = $clog2(STEP_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_TICKS - 1);

    localparam logic [1:0] MODE_TOGGLE  = 2'd0;
    localparam logic [1:0] MODE_WALK    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_COUNT   = 2'd3;

    logic [TIMER_W-1:0] timer;
    logic [1:0]         mode_q;
    logic               mode_chg;
    logic               tick;
    logic [TOTAL_W-1:0] next_pattern;

    function automatic logic [TOTAL_W-1:0] init_pattern(input logic [1:0] m);
        logic [TOTAL_W-1:0] p;
        p = '0;
        case (m)
            MODE_WALK:    p[0] = 1'b1;
            MODE_CHECKER: for (int i = 0; i < TOTAL_W; i += 2) p[i] = 1'b1;
            default:      p = '0;
        endcase
        return p;
    endfunction

    assign mode_chg = (mode != mode_q);
    assign tick     = en && (timer == TIMER_LAST);

    // COUNT increments every port independently so each port wraps within its own width.
    always_comb begin
        next_pattern = ~io_out;
        case (mode_q)
            MODE_WALK:   next_pattern = {io_out[TOTAL_W-2:0], io_out[TOTAL_W-1]};
            MODE_COUNT: begin
                for (int k = 0; k < NUM_PORTS; k++)
                    next_pattern[k*PORT_W +: PORT_W] = io_out[k*PORT_W +: PORT_W] + 1'b1;
            end
            MODE_TOGGLE, MODE_CHECKER: next_pattern = ~io_out;
            default:     next_pattern = ~io_out;
        endcase
    end

    // A mode change re-initialises everything and wins over a coincident tick, even while paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            step_cnt   <= '0;
            step_pulse <= 1'b0;
            mode_q     <= mode;
            io_out     <= init_pattern(mode);
        end else if (mode_chg) begin
            timer      <= '0;
            step_cnt   <= '0;
            step_pulse <= 1'b0;
            mode_q     <= mode;
            io_out     <= init_pattern(mode);
        end else if (tick) begin
            timer      <= '0;
            step_cnt   <= step_cnt + 1'b1;
            step_pulse <= 1'b1;
            io_out     <= next_pattern;
        end else begin
            step_pulse <= 1'b0;
            if (en)
                timer <= timer + 1'b1;
        end
    end

`ifdef IO_PATTERN_LOOPBACK_EN
    // Pins are compared against the pattern being replaced, only on ticks that actually advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (tick && !mode_chg && (io_in != io_out)) begin
            err_flag <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_io_pattern_gen.sv
// Self-checking bench for io_pattern_gen (2 ports x 4 bits, 4-clock steps): vector table, directed sequences, random run vs. a step-count model.
module tb_io_pattern_gen;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_W     = 4;
    localparam int STEP_TICKS = 4;
    localparam int CNT_W      = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] io_out;
    logic       step_pulse;
    logic [3:0] step_cnt;
`ifdef IO_PATTERN_LOOPBACK_EN
    logic [7:0] io_in;
    logic [7:0] force_mask;
    logic [3:0] err_cnt;
    logic       err_flag;
    assign io_in = io_out | force_mask;
`endif

    io_pattern_gen #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W),
        .STEP_TICKS(STEP_TICKS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
`ifdef IO_PATTERN_LOOPBACK_EN
        .io_in     (io_in),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
`endif
        .io_out    (io_out),
        .step_pulse(step_pulse),
        .step_cnt  (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the pattern is a closed-form function of mode and steps taken since re-init.
    logic [1:0] m_mode  = 2'd0;
    int         m_steps = 0;
    int         m_phase = 0;
    logic       m_pulse = 1'b0;
    int         m_err   = 0;
    logic       m_flag  = 1'b0;

    function automatic logic [7:0] exp_pattern(input logic [1:0] md, input int steps);
        logic [7:0] one;
        logic [3:0] c;
        one = 8'h01;
        c   = 4'(steps % 16);
        case (md)
            2'd0:    return (steps % 2 == 1) ? 8'hFF : 8'h00;
            2'd1:    return one << (steps % 8);
            2'd2:    return (steps % 2 == 1) ? 8'hAA : 8'h55;
            default: return {c, c};
        endcase
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic [1:0] md);
        logic [7:0] cur;
        if (r) begin
            m_mode = md; m_steps = 0; m_phase = 0; m_pulse = 1'b0; m_err = 0; m_flag = 1'b0;
        end else if (md != m_mode) begin
            m_mode = md; m_steps = 0; m_phase = 0; m_pulse = 1'b0;
        end else if (e && m_phase == STEP_TICKS - 1) begin
            cur = exp_pattern(m_mode, m_steps);
`ifdef IO_PATTERN_LOOPBACK_EN
            if ((cur | force_mask) != cur) begin
                if (m_err < 15) m_err++;
                m_flag = 1'b1;
            end
`endif
            m_steps++; m_phase = 0; m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
            if (e) m_phase++;
        end
    endtask

    task automatic checkOutput();
        check_val("io_out", 32'(io_out), 32'(exp_pattern(m_mode, m_steps)));
        check_val("step_pulse", 32'(step_pulse), 32'(m_pulse));
        check_val("step_cnt", 32'(step_cnt), 32'(m_steps % 16));
`ifdef IO_PATTERN_LOOPBACK_EN
        check_val("err_cnt", 32'(err_cnt), 32'(m_err));
        check_val("err_flag", 32'(err_flag), 32'(m_flag));
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] md);
        rst  = r;
        en   = e;
        mode = md;
        @(posedge clk);
        model_update(r, e, md);
        @(negedge clk);
        checkOutput();
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] exp_io;
        logic       exp_pulse;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic e, input logic [1:0] md,
                           input logic [7:0] eio, input logic ep, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.en = e; v.mode = md; v.exp_io = eio; v.exp_pulse = ep; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    logic [7:0] walk_tab [8];
    logic       r_rnd;
    logic       e_rnd;
    logic [1:0] cur_mode;

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'd0;
`ifdef IO_PATTERN_LOOPBACK_EN
        force_mask = 8'h00;
`endif
        walk_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset, first TOGGLE step, switch to WALK and its first step.
        add_vec(1, 1, 0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 8'h00, 0, 0);
        add_vec(0, 1, 0, 8'h00, 0, 0);
        add_vec(0, 1, 0, 8'h00, 0, 0);
        add_vec(0, 1, 0, 8'h00, 0, 0);
        add_vec(0, 1, 0, 8'hFF, 1, 1);
        add_vec(0, 1, 0, 8'hFF, 0, 1);
        add_vec(0, 1, 1, 8'h01, 0, 0);
        add_vec(0, 1, 1, 8'h01, 0, 0);
        add_vec(0, 1, 1, 8'h01, 0, 0);
        add_vec(0, 1, 1, 8'h01, 0, 0);
        add_vec(0, 1, 1, 8'h02, 1, 1);
        add_vec(0, 1, 1, 8'h02, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode);
            check_val("vec_io", 32'(io_out), 32'(vecs[i].exp_io));
            check_val("vec_pulse", 32'(step_pulse), 32'(vecs[i].exp_pulse));
            check_val("vec_cnt", 32'(step_cnt), 32'(vecs[i].exp_cnt));
        end

        // WALK continues through 80 and wraps back to 01 at step 8.
        for (int s = 2; s <= 8; s++) begin
            repeat ((s == 2) ? 3 : 4) applyStimulus(0, 1, 1);
            check_val("walk_io", 32'(io_out), 32'(walk_tab[s % 8]));
            check_val("walk_pulse", 32'(step_pulse), 32'd1);
        end

        // COUNT for 17 steps: ports and step_cnt both wrap.
        applyStimulus(0, 1, 3);
        check_val("count_init", 32'(io_out), 32'h00);
        repeat (68) applyStimulus(0, 1, 3);
        check_val("count_17_io", 32'(io_out), 32'h11);
        check_val("count_17_cnt", 32'(step_cnt), 32'd1);

        // CHECKER alternates 55 / AA.
        applyStimulus(0, 1, 2);
        check_val("chk_init", 32'(io_out), 32'h55);
        repeat (4) applyStimulus(0, 1, 2);
        check_val("chk_1", 32'(io_out), 32'hAA);
        repeat (4) applyStimulus(0, 1, 2);
        check_val("chk_2", 32'(io_out), 32'h55);

        // Pause at timer=2 keeps the partial count; step lands 2 cycles after resume.
        repeat (2) applyStimulus(0, 1, 2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 2);
            check_val("pause_io", 32'(io_out), 32'h55);
            check_val("pause_pulse", 32'(step_pulse), 32'd0);
        end
        applyStimulus(0, 1, 2);
        check_val("resume_1_pulse", 32'(step_pulse), 32'd0);
        applyStimulus(0, 1, 2);
        check_val("resume_2_pulse", 32'(step_pulse), 32'd1);
        check_val("resume_2_io", 32'(io_out), 32'hAA);

        // Mode change coinciding with a tick, then reset mid-step.
        repeat (3) applyStimulus(0, 1, 2);
        applyStimulus(0, 1, 0);
        check_val("chg_tick_io", 32'(io_out), 32'h00);
        check_val("chg_tick_pulse", 32'(step_pulse), 32'd0);
        check_val("chg_tick_cnt", 32'(step_cnt), 32'd0);
        repeat (2) applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        repeat (3) begin
            applyStimulus(0, 1, 0);
            check_val("rst_mid_pulse", 32'(step_pulse), 32'd0);
        end
        applyStimulus(0, 1, 0);
        check_val("rst_mid_step", 32'(step_pulse), 32'd1);
        check_val("rst_mid_io", 32'(io_out), 32'hFF);

`ifdef IO_PATTERN_LOOPBACK_EN
        // Loopback: clean pins, then bit3 stuck high until err_cnt saturates.
        applyStimulus(1, 1, 1);
        repeat (80) applyStimulus(0, 1, 1);
        check_val("lb_clean_cnt", 32'(err_cnt), 32'd0);
        check_val("lb_clean_flag", 32'(err_flag), 32'd0);
        force_mask = 8'h08;
        repeat (80) applyStimulus(0, 1, 1);
        check_val("lb_sat_cnt", 32'(err_cnt), 32'hF);
        check_val("lb_sat_flag", 32'(err_flag), 32'd1);
        force_mask = 8'h00;
        applyStimulus(0, 1, 2);
        check_val("lb_modechg_flag", 32'(err_flag), 32'd1);
        check_val("lb_modechg_cnt", 32'(err_cnt), 32'hF);
        applyStimulus(1, 1, 2);
        check_val("lb_rst_flag", 32'(err_flag), 32'd0);
        check_val("lb_rst_cnt", 32'(err_cnt), 32'd0);
`endif

        // Randomized run against the model.
        cur_mode = 2'd0;
        for (int c = 0; c < 1500; c++) begin
            r_rnd = ($urandom_range(0, 149) == 0);
            e_rnd = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0)
                cur_mode = 2'($urandom_range(0, 3));
`ifdef IO_PATTERN_LOOPBACK_EN
            force_mask = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
`endif
            applyStimulus(r_rnd, e_rnd, cur_mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
